// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO byte serializer.
// FIFO_SER_PARITY_EN adds the PAR state to the state enum.
package fifo_ser_pkg;

    localparam int   DATA_W_DEF = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
`ifdef FIFO_SER_PARITY_EN
        PAR   = 3'd5,
`endif
        STOP  = 3'd6
    } ser_state_t;

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on terminal count.
// Latency: tick is combinational from the count register; no backpressure.
module ser_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops one byte per frame from a FIFO and sends start, LSB-first data, [even parity], stop.
// Latency: fifo_rd one cycle after a non-empty IDLE, start bit two cycles later; FIFO is only read when idle.
// FIFO_SER_PARITY_EN compiles in the parity bit between data and stop.
module fifo_byte_serializer
    import fifo_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    ser_state_t        state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              bit_tick, tmr_clear, tmr_en;
    logic              tx_nxt, fifo_rd_nxt, frame_done_nxt;
`ifdef FIFO_SER_PARITY_EN
    logic              parity, parity_nxt;
`endif

    assign tmr_clear = (state == LOAD);
    assign tmr_en    = (state != IDLE) && (state != REQ) && (state != LOAD);
    assign busy      = (state != IDLE);

    ser_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clear (tmr_clear),
        .enable(tmr_en),
        .count (bit_cnt),
        .tick  (bit_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        idx_nxt   = idx;
`ifdef FIFO_SER_PARITY_EN
        parity_nxt = parity;
`endif
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = REQ;
            REQ:   state_nxt = LOAD;
            LOAD: begin
                shift_nxt = fifo_data;
                idx_nxt   = '0;
`ifdef FIFO_SER_PARITY_EN
                parity_nxt = ^fifo_data;
`endif
                state_nxt = START;
            end
            START: if (bit_tick) state_nxt = DATA;
            DATA: begin
                if (bit_tick) begin
                    shift_nxt = shift >> 1;
                    idx_nxt   = idx + 1'b1;
                    if (idx_nxt == LAST_IDX) begin
`ifdef FIFO_SER_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_SER_PARITY_EN
            PAR:   if (bit_tick) state_nxt = STOP;
`endif
            STOP:  if (bit_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        fifo_rd_nxt    = (state_nxt == REQ);
        frame_done_nxt = (state == STOP) && (bit_cnt == PRE_LAST);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
`ifdef FIFO_SER_PARITY_EN
            PAR:     tx_nxt = parity_nxt;
`endif
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift      <= '0;
            idx        <= '0;
            tx         <= IDLE_LEVEL;
            fifo_rd    <= 1'b0;
            frame_done <= 1'b0;
`ifdef FIFO_SER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            shift      <= shift_nxt;
            idx        <= idx_nxt;
            tx         <= tx_nxt;
            fifo_rd    <= fifo_rd_nxt;
            frame_done <= frame_done_nxt;
`ifdef FIFO_SER_PARITY_EN
            parity     <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer at CLKS_PER_BIT=4; cycle 0 of a frame is the REQ cycle.
module tb_fifo_byte_serializer;
    localparam int CPB = 4;
`ifdef FIFO_SER_PARITY_EN
    localparam int PAR_CYC = 4;
`else
    localparam int PAR_CYC = 0;
`endif
    // frame_done cycle: LOAD is cycle 1, stop ends 40 (44 with parity) cycles later
    localparam int FD = 41 + PAR_CYC;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd, tx, busy, frame_done;

    int vectors = 0;
    int miscompares = 0;
    int rd_pulses = 0;
    logic [7:0] q[$];

    fifo_byte_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Advance to the next falling edge and behave as the FIFO for a read seen this cycle.
    task automatic cyc();
        @(negedge clock);
        if (fifo_rd === 1'b1) begin
            rd_pulses++;
            if (q.size() > 0) fifo_data = q.pop_front();
            fifo_empty = (q.size() == 0);
        end
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int c);
        if (c < 2)            return 1'b1;
        if (c < 6)            return 1'b0;
        if (c < 38)           return b[(c - 6) / 4];
        if (c < 38 + PAR_CYC) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        fifo_empty = 1'b1;
        cyc();
        cyc();
        vectors++;
        if ({tx, fifo_rd, busy, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_state: tx/rd/busy/done=%b want 1000", {tx, fifo_rd, busy, frame_done});
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            vectors++;
            if ({tx, fifo_rd, busy, frame_done} !== 4'b1000) begin
                miscompares++;
                $display("FAIL idle_empty cycle %0d: tx/rd/busy/done=%b want 1000", c, {tx, fifo_rd, busy, frame_done});
            end
        end
    endtask

    task automatic test_single_byte();
        rd_pulses = 0;
        q.push_back(8'hA5);
        fifo_empty = 1'b0;
        for (int c = 0; c < FD + 4; c++) begin
            cyc();
            vectors++;
            if (tx !== exp_tx(8'hA5, c)) begin
                miscompares++;
                $display("FAIL single_tx cycle %0d: got %b want %b", c, tx, exp_tx(8'hA5, c));
            end
            vectors++;
            if (fifo_rd !== 1'(c == 0)) begin
                miscompares++;
                $display("FAIL single_rd cycle %0d: got %b want %b", c, fifo_rd, c == 0);
            end
            vectors++;
            if (frame_done !== 1'(c == FD)) begin
                miscompares++;
                $display("FAIL single_done cycle %0d: got %b want %b", c, frame_done, c == FD);
            end
            vectors++;
            if (busy !== 1'(c <= FD)) begin
                miscompares++;
                $display("FAIL single_busy cycle %0d: got %b want %b", c, busy, c <= FD);
            end
        end
        vectors++;
        if (rd_pulses !== 1) begin
            miscompares++;
            $display("FAIL single_rd_count: got %0d want 1", rd_pulses);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int done_at;
        int first_low;
        logic want;
        rd_pulses = 0;
        done_cnt = 0;
        done_at = -1;
        first_low = -1;
        q.push_back(8'h01);
        q.push_back(8'hFF);
        fifo_empty = 1'b0;
        for (int c = 0; c < 2 * FD + 6; c++) begin
            cyc();
            want = (c <= FD + 1) ? exp_tx(8'h01, c) : exp_tx(8'hFF, c - (FD + 2));
            vectors++;
            if (tx !== want) begin
                miscompares++;
                $display("FAIL b2b_tx cycle %0d: got %b want %b", c, tx, want);
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_at = c;
            end
            if (done_at >= 0 && c > done_at && first_low < 0 && tx === 1'b0) first_low = c;
        end
        vectors++;
        if (first_low - done_at - 1 !== 3) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d idle cycles want 3", first_low - done_at - 1);
        end
        vectors++;
        if (rd_pulses !== 2) begin
            miscompares++;
            $display("FAIL b2b_rd_count: got %0d want 2", rd_pulses);
        end
        vectors++;
        if (done_cnt !== 2) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d want 2", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_cnt;
        done_cnt = 0;
        q.push_back(8'h3C);
        fifo_empty = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            vectors++;
            if (tx !== exp_tx(8'h3C, c)) begin
                miscompares++;
                $display("FAIL abort_pre_tx cycle %0d: got %b want %b", c, tx, exp_tx(8'h3C, c));
            end
        end
        // cycle 15 is inside the third data bit (cycles 14..17)
        reset = 1'b1;
        cyc();
        vectors++;
        if ({tx, busy, frame_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_state: tx/busy/done=%b want 100", {tx, busy, frame_done});
        end
        reset = 1'b0;
        for (int c = 0; c < FD + 4; c++) begin
            cyc();
            if (frame_done === 1'b1) done_cnt++;
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_idle_busy cycle %0d: got %b want 0", c, busy);
            end
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
        end
        q.push_back(8'h5A);
        fifo_empty = 1'b0;
        for (int c = 0; c < FD + 3; c++) begin
            cyc();
            vectors++;
            if (tx !== exp_tx(8'h5A, c)) begin
                miscompares++;
                $display("FAIL after_abort_tx cycle %0d: got %b want %b", c, tx, exp_tx(8'h5A, c));
            end
            vectors++;
            if (frame_done !== 1'(c == FD)) begin
                miscompares++;
                $display("FAIL after_abort_done cycle %0d: got %b want %b", c, frame_done, c == FD);
            end
        end
    endtask

    task automatic test_empty_toggle();
        rd_pulses = 0;
        q.push_back(8'h96);
        fifo_empty = 1'b0;
        for (int c = 0; c < FD + 6; c++) begin
            cyc();
            if (c >= 6 && c < 38) fifo_empty = (c % 2 == 0);
            else if (c == 38) fifo_empty = 1'b1;
            if (c >= 1 && c <= FD) begin
                vectors++;
                if (fifo_rd !== 1'b0) begin
                    miscompares++;
                    $display("FAIL toggle_rd cycle %0d: got %b want 0", c, fifo_rd);
                end
            end
            vectors++;
            if (tx !== exp_tx(8'h96, c)) begin
                miscompares++;
                $display("FAIL toggle_tx cycle %0d: got %b want %b", c, tx, exp_tx(8'h96, c));
            end
        end
        vectors++;
        if (rd_pulses !== 1) begin
            miscompares++;
            $display("FAIL toggle_rd_count: got %0d want 1", rd_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
